// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl: stall/flush/bubble sequencer for a 5-stage RV32I pipe. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              hazard_lu;
  logic              mem_stall;
  logic              freeze;
  logic              redirect_take;
  logic              count_en;

  assign hazard_lu = ex_memread && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = mem_req && !mem_ready;
  // Once waiting, only mem_ready releases the freeze; mem_req is not re-qualified.
  assign freeze    = (state == MEM_WAIT) ? !mem_ready : mem_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    wait_nx       = wait_cnt;
    pc_we         = 1'b0;
    ifid_we       = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b1;
    exmem_we      = 1'b0;
    mem_timeout   = 1'b0;
    redirect_take = 1'b0;
    count_en      = 1'b0;
    if (!reset) begin
      case (state)
        RUN, MEM_WAIT: begin
          count_en = 1'b1;
          if (freeze) begin
            idex_bubble = 1'b0;
            if (state == RUN) begin
              state_nx = MEM_WAIT;
              wait_nx  = WAIT_W'(1);
            end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
              state_nx = ERR;
            end else begin
              wait_nx = wait_cnt + WAIT_W'(1);
            end
          end else begin
            state_nx = RUN;
            wait_nx  = '0;
            if (ex_redirect) begin
              pc_we         = 1'b1;
              ifid_we       = 1'b1;
              ifid_flush    = 1'b1;
              exmem_we      = 1'b1;
              redirect_take = 1'b1;
            end else if (hazard_lu) begin
              exmem_we = 1'b1;
            end else begin
              pc_we       = 1'b1;
              ifid_we     = 1'b1;
              idex_bubble = 1'b0;
              exmem_we    = 1'b1;
            end
          end
        end
        ERR: begin
          mem_timeout = 1'b1;
        end
        default: begin
          state_nx = RUN;
          wait_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (count_en) begin
      if (!pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_take && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl: vectors, corner sequences and random run vs a reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int MW   = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memread = 1'b0;
  logic          ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b1;
  logic          pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [4:0]    outs;

  pipeline_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_we(exmem_we), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we}
  assign outs = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we};

  typedef struct {
    logic [4:0] rs1, rs2, exrd;
    logic       u1, u2, exmr, redir, req, rdy;
    logic [4:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: length of the current run of frozen cycles, error flag, counters.
  int m_run = 0;
  bit m_err = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic vec_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                              input int exrd, input bit exmr, input bit redir,
                              input bit req, input bit rdy, input logic [4:0] exp);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.exrd = 5'(exrd);
    v.exmr = exmr; v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic bit m_busy(input vec_t v);
    return (m_run > 0) ? !v.rdy : (v.req && !v.rdy);
  endfunction

  function automatic bit m_lu(input vec_t v);
    return v.exmr && v.exrd != 0 &&
           ((v.u1 && v.rs1 == v.exrd) || (v.u2 && v.rs2 == v.exrd));
  endfunction

  function automatic logic [4:0] m_outs(input vec_t v);
    if (m_err)        return 5'b00010;
    if (m_busy(v))    return 5'b00000;
    if (v.redir)      return 5'b11111;
    if (m_lu(v))      return 5'b00011;
    return 5'b11001;
  endfunction

  task automatic m_step(input vec_t v);
    logic [4:0] o;
    if (m_err) return;
    o = m_outs(v);
    if (!o[4] && m_stall < CMAX) m_stall++;
    if (!m_busy(v) && v.redir && m_flush < CMAX) m_flush++;
    if (m_busy(v)) begin
      if (m_run + 1 == MW + 1) m_err = 1'b1;
      m_run++;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.exrd; ex_memread = v.exmr; ex_redirect = v.redir;
    mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic cycle(input vec_t v, input bit use_tab, input string nm);
    @(negedge clk);
    drive(v);
    #2;
    chk({nm, " outs"}, int'(outs), int'(use_tab ? v.exp : m_outs(v)));
    chk({nm, " stall_cnt"}, int'(stall_cnt), m_stall);
    chk({nm, " flush_cnt"}, int'(flush_cnt), m_flush);
    chk({nm, " mem_timeout"}, int'(mem_timeout), int'(m_err));
    m_step(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b0));
    #2;
    chk("reset outs", int'(outs), 5'b00010);
    chk("reset stall_cnt", int'(stall_cnt), 0);
    chk("reset flush_cnt", int'(flush_cnt), 0);
    chk("reset mem_timeout", int'(mem_timeout), 0);
    m_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    #4;
    reset = 1'b0;
  endtask

  vec_t tab[10];
  vec_t idle;

  initial begin
    idle = mk(1, 2, 1, 1, 3, 0, 0, 0, 1, 5'b11001);
    tab[0] = idle;
    tab[1] = mk(0, 5, 0, 1, 5, 1, 0, 0, 1, 5'b00011);
    tab[2] = mk(0, 5, 0, 1, 5, 0, 0, 0, 1, 5'b11001);
    tab[3] = mk(7, 0, 1, 0, 7, 1, 0, 0, 1, 5'b00011);
    tab[4] = mk(7, 0, 0, 0, 7, 1, 0, 0, 1, 5'b11001);
    tab[5] = mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 5'b11001);
    tab[6] = mk(5, 0, 1, 0, 5, 1, 1, 0, 1, 5'b11111);
    tab[7] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000);
    tab[8] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11111);
    tab[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001);

    do_reset();
    for (int i = 0; i < 10; i++) cycle(tab[i], 1'b1, $sformatf("vec%0d", i));

    // single load-use bubble
    do_reset();
    cycle(tab[1], 1'b1, "lu");
    cycle(tab[2], 1'b1, "lu_after");
    chk("lu stall_cnt", int'(stall_cnt), 1);

    // redirect beats load-use
    do_reset();
    cycle(tab[6], 1'b1, "redir_lu");
    cycle(idle, 1'b1, "redir_after");
    chk("redir flush_cnt", int'(flush_cnt), 1);
    chk("redir stall_cnt", int'(stall_cnt), 0);

    // three wait states then completion
    do_reset();
    for (int i = 0; i < 3; i++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000), 1'b1, "wait3");
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11001), 1'b1, "wait3_done");
    cycle(idle, 1'b1, "wait3_run");
    chk("wait3 stall_cnt", int'(stall_cnt), 3);

    // timeout: MW+1 frozen cycles reach ERR, flag stays with mem_ready=1
    do_reset();
    for (int i = 0; i < MW + 1; i++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000), 1'b1, "tmo_wait");
    for (int i = 0; i < 3; i++) cycle(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b00010), 1'b1, "tmo_err");
    chk("tmo flag", int'(mem_timeout), 1);
    chk("tmo stall_cnt frozen", int'(stall_cnt), MW + 1);
    do_reset();
    cycle(idle, 1'b1, "tmo_cleared");

    // flush counter saturation
    do_reset();
    for (int i = 0; i < CMAX + 2; i++) cycle(tab[8], 1'b1, "sat");
    cycle(idle, 1'b1, "sat_after");
    chk("sat flush_cnt", int'(flush_cnt), CMAX);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      if ($urandom_range(99) < 3) begin
        do_reset();
      end else begin
        v = mk($urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
               $urandom_range(3), 1'($urandom), $urandom_range(99) < 20,
               $urandom_range(99) < 40, $urandom_range(99) < 60, 5'b0);
        cycle(v, 1'b0, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
